// File: rtl/hazard_detection_ml_if.sv
// Pipeline hazard-control bundle between the ID stage and the hazard unit.
// The master side drives the pipeline inputs; the slave side (hazard unit) returns controls.
interface hazard_detection_ml_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              ID_EX_MEMR_i;
  logic [REG_AW-1:0] ID_EX_RD_i;
  logic [REG_AW-1:0] RS1_i;
  logic [REG_AW-1:0] RS2_i;
  logic              RS1_used_i;
  logic              RS2_used_i;
  logic              Mem_stall_i;
  logic              Branch_taken_i;
  logic              PCWrite_o;
  logic              IF_ID_Write_o;
  logic              BubbleSignal_o;
  logic              IF_ID_Flush_o;
  logic [CNT_W-1:0]  StallCnt_o;

  modport master (
    output ID_EX_MEMR_i, ID_EX_RD_i, RS1_i, RS2_i, RS1_used_i, RS2_used_i,
           Mem_stall_i, Branch_taken_i,
    input  PCWrite_o, IF_ID_Write_o, BubbleSignal_o, IF_ID_Flush_o, StallCnt_o
  );

  modport slave (
    input  ID_EX_MEMR_i, ID_EX_RD_i, RS1_i, RS2_i, RS1_used_i, RS2_used_i,
           Mem_stall_i, Branch_taken_i,
    output PCWrite_o, IF_ID_Write_o, BubbleSignal_o, IF_ID_Flush_o, StallCnt_o
  );
endinterface

// File: rtl/hazard_detection_ml.sv
// Multi-latency load-use hazard unit: pending-load scoreboard, freeze, branch flush.
// Optional bubble counter is built when HAZARD_STALL_CNT_EN is defined.
module hazard_detection_ml #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  hazard_detection_ml_if.slave bus
);
  localparam int SLOTS = LOAD_LAT - 1;

  function automatic logic reads(input logic [REG_AW-1:0] r,
                                 input logic [REG_AW-1:0] rs1, input logic u1,
                                 input logic [REG_AW-1:0] rs2, input logic u2);
    return (r != '0) && ((u1 && (rs1 == r)) || (u2 && (rs2 == r)));
  endfunction

  logic live_hit, slot_hit, luh;
  logic pcw, ifw, bub, flush;

  // With LOAD_LAT == 1 and no counter nothing is clocked.
  logic unused_clk;
  assign unused_clk = clk_i;

  assign live_hit = bus.ID_EX_MEMR_i &&
                    reads(bus.ID_EX_RD_i, bus.RS1_i, bus.RS1_used_i, bus.RS2_i, bus.RS2_used_i);

  generate
    if (SLOTS > 0) begin : g_sb
      logic [SLOTS-1:0]             vld_q, vld_d, hit;
      logic [SLOTS-1:0][REG_AW-1:0] rd_q, rd_d;

      // A load ages one slot per unfrozen edge; rd==0 never occupies a slot.
      always_comb begin
        vld_d = vld_q;
        rd_d  = rd_q;
        if (!bus.Mem_stall_i) begin
          vld_d[0] = bus.ID_EX_MEMR_i && (bus.ID_EX_RD_i != '0);
          rd_d[0]  = bus.ID_EX_RD_i;
          for (int k = 1; k < SLOTS; k++) begin
            vld_d[k] = vld_q[k-1];
            rd_d[k]  = rd_q[k-1];
          end
        end
      end

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          vld_q <= '0;
          rd_q  <= '0;
        end else begin
          vld_q <= vld_d;
          rd_q  <= rd_d;
        end
      end

      for (genvar k = 0; k < SLOTS; k++) begin : g_hit
        assign hit[k] = vld_q[k] &&
                        reads(rd_q[k], bus.RS1_i, bus.RS1_used_i, bus.RS2_i, bus.RS2_used_i);
      end
      assign slot_hit = |hit;
    end else begin : g_nosb
      assign slot_hit = 1'b0;
    end
  endgenerate

  assign luh = live_hit || slot_hit;

  // Freeze beats load-use beats branch flush; reset forces the free-running values.
  always_comb begin
    pcw   = 1'b1;
    ifw   = 1'b1;
    bub   = 1'b0;
    flush = 1'b0;
    if (rst_n_i) begin
      if (bus.Mem_stall_i) begin
        pcw = 1'b0;
        ifw = 1'b0;
      end else if (luh) begin
        pcw = 1'b0;
        ifw = 1'b0;
        bub = 1'b1;
      end else if (bus.Branch_taken_i) begin
        flush = 1'b1;
      end
    end
  end

  assign bus.PCWrite_o      = pcw;
  assign bus.IF_ID_Write_o  = ifw;
  assign bus.BubbleSignal_o = bub;
  assign bus.IF_ID_Flush_o  = flush;

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (bub && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign bus.StallCnt_o = cnt_q;
`else
  assign bus.StallCnt_o = '0;
`endif
endmodule

// File: tb/tb_hazard_detection_ml.sv
// Scoreboard bench: four DUTs (LOAD_LAT 1..4) share stimulus; each record names the instance it checks.
module tb_hazard_detection_ml;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       memr = 1'b0, u1 = 1'b0, u2 = 1'b0, ms = 1'b0, br = 1'b0;
  logic [4:0] rd = '0, rs1 = '0, rs2 = '0;

  logic [3:0][3:0] outs;
  logic [3:0][1:0] cnts;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    hazard_detection_ml_if #(.REG_AW(5), .CNT_W(2)) bus ();
    assign bus.ID_EX_MEMR_i   = memr;
    assign bus.ID_EX_RD_i     = rd;
    assign bus.RS1_i          = rs1;
    assign bus.RS2_i          = rs2;
    assign bus.RS1_used_i     = u1;
    assign bus.RS2_used_i     = u2;
    assign bus.Mem_stall_i    = ms;
    assign bus.Branch_taken_i = br;
    assign outs[g] = {bus.PCWrite_o, bus.IF_ID_Write_o, bus.BubbleSignal_o, bus.IF_ID_Flush_o};
    assign cnts[g] = bus.StallCnt_o;
    hazard_detection_ml #(.REG_AW(5), .LOAD_LAT(g+1), .CNT_W(2)) u_dut (
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .bus    (bus)
    );
  end

`ifdef HAZARD_STALL_CNT_EN
  localparam logic CE = 1'b1;
`else
  localparam logic CE = 1'b0;
`endif

  // {PCWrite, IF_ID_Write, Bubble, Flush}
  localparam logic [3:0] N = 4'b1100;
  localparam logic [3:0] B = 4'b0010;
  localparam logic [3:0] F = 4'b1101;
  localparam logic [3:0] Z = 4'b0000;

  typedef struct {
    int         inst;
    logic [3:0] exp;
    logic       chk_cnt;
    logic [1:0] ecnt;
    string      name;
  } rec_t;

  rec_t q[$];
  int   sel = 0;
  int   checks = 0;
  int   errors = 0;
  event mid_ev;

  task automatic push(input logic [3:0] e, input string nm, input logic ck, input logic [1:0] ec);
    rec_t r;
    r.inst = sel; r.exp = e; r.chk_cnt = ck | !CE; r.ecnt = CE ? ec : 2'd0; r.name = nm;
    q.push_back(r);
  endtask

  task automatic step(input logic m, input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                      input logic ua, input logic ub, input logic s, input logic bt,
                      input logic [3:0] e, input string nm,
                      input logic ck = 1'b0, input logic [1:0] ec = 2'd0);
    @(posedge clk); #1;
    memr = m; rd = d; rs1 = a; rs2 = b; u1 = ua; u2 = ub; ms = s; br = bt;
    push(e, nm, ck, ec);
  endtask

  // Reset is held with hazardous inputs applied; outputs must still read free-running.
  task automatic do_reset(input int ll, input string nm);
    @(posedge clk); #1;
    sel = ll - 1;
    rst_n = 1'b0;
    memr = 1'b1; rd = 5'd5; rs1 = 5'd5; rs2 = 5'd5; u1 = 1'b1; u2 = 1'b1; ms = 1'b0; br = 1'b1;
    push(N, nm, 1'b1, 2'd0);
    @(negedge clk); #1;
    memr = 1'b0; rd = '0; rs1 = '0; rs2 = '0; u1 = 1'b0; u2 = 1'b0; br = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    rec_t r;
    forever begin
      @(negedge clk or mid_ev);
      if (q.size() > 0) begin
        r = q.pop_front();
        checks++;
        if (outs[r.inst] !== r.exp) begin
          errors++;
          $display("FAIL %s: pcw/ifw/bub/flush got %b want %b", r.name, outs[r.inst], r.exp);
        end
        if (r.chk_cnt) begin
          checks++;
          if (cnts[r.inst] !== r.ecnt) begin
            errors++;
            $display("FAIL %s_cnt: StallCnt got %0d want %0d", r.name, cnts[r.inst], r.ecnt);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // LOAD_LAT=1: single bubble, operand-use qualification
    do_reset(1, "rst_ll1");
    step(1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, B, "ll1_use");
    step(0, 5'd0, 5'd5, 5'd0, 1, 0, 0, 0, N, "ll1_release");
    step(1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, N, "ll1_unused");
    step(1, 5'd5, 5'd0, 5'd5, 0, 1, 0, 0, B, "ll1_rs2");
    step(0, 5'd0, 5'd0, 5'd5, 0, 1, 0, 0, N, "ll1_rs2_release");

    // LOAD_LAT=3: immediate dependency on both sources, then distance 2
    do_reset(3, "rst_ll3");
    step(1, 5'd7, 5'd7, 5'd7, 1, 1, 0, 0, B, "ll3_d1_b1");
    step(0, 5'd0, 5'd7, 5'd7, 1, 1, 0, 0, B, "ll3_d1_b2");
    step(0, 5'd0, 5'd7, 5'd7, 1, 1, 0, 0, B, "ll3_d1_b3");
    step(0, 5'd0, 5'd7, 5'd7, 1, 1, 0, 0, N, "ll3_d1_go");
    do_reset(3, "rst_ll3b");
    step(1, 5'd7, 5'd1, 5'd0, 1, 0, 0, 0, N, "ll3_d2_load");
    step(0, 5'd1, 5'd7, 5'd0, 1, 0, 0, 0, B, "ll3_d2_b1");
    step(0, 5'd0, 5'd7, 5'd0, 1, 0, 0, 0, B, "ll3_d2_b2");
    step(0, 5'd0, 5'd7, 5'd0, 1, 0, 0, 0, N, "ll3_d2_go");

    // LOAD_LAT=2: freeze in the middle of a load-use stall
    do_reset(2, "rst_ll2");
    step(1, 5'd3, 5'd3, 5'd0, 1, 0, 0, 0, B, "ll2_b1");
    for (int i = 0; i < 4; i++)
      step(0, 5'd0, 5'd3, 5'd0, 1, 0, 1, 0, Z, "ll2_freeze");
    step(0, 5'd0, 5'd3, 5'd0, 1, 0, 0, 0, B, "ll2_b2");
    step(0, 5'd0, 5'd3, 5'd0, 1, 0, 0, 0, N, "ll2_go");

    // x0 loads, branch flush, branch masked by hazard, freeze over branch
    do_reset(2, "rst_br");
    step(1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, N, "x0_load");
    step(0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, N, "x0_next");
    step(0, 5'd0, 5'd1, 5'd2, 1, 1, 0, 1, F, "br_flush");
    step(1, 5'd4, 5'd0, 5'd4, 0, 1, 0, 1, B, "br_haz1");
    step(0, 5'd0, 5'd0, 5'd4, 0, 1, 0, 1, B, "br_haz2");
    step(0, 5'd0, 5'd0, 5'd4, 0, 1, 0, 1, F, "br_go");
    step(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, Z, "ms_over_br");

    // LOAD_LAT=4: async reset pulse between edges during the second bubble
    do_reset(4, "rst_ll4");
    step(1, 5'd6, 5'd6, 5'd0, 1, 0, 0, 0, B, "ll4_b1");
    step(0, 5'd0, 5'd6, 5'd0, 1, 0, 0, 0, B, "ll4_b2");
    @(negedge clk); #1;
    rst_n = 1'b0;
    push(N, "ll4_rst_mid", 1'b1, 2'd0);
    #1 -> mid_ev;
    #1 rst_n = 1'b1;
    step(0, 5'd0, 5'd6, 5'd0, 1, 0, 0, 0, N, "ll4_after1");
    step(0, 5'd0, 5'd6, 5'd0, 1, 0, 0, 0, N, "ll4_after2");
    step(0, 5'd0, 5'd6, 5'd0, 1, 0, 0, 0, N, "ll4_after3");

    // Counter: five bubbles on a 2-bit counter saturate at 3
    do_reset(1, "rst_cnt");
    step(1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, B, "cnt_b1");
    step(0, 5'd0, 5'd5, 5'd0, 1, 0, 0, 0, N, "cnt_i1", 1'b1, 2'd1);
    step(1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, B, "cnt_b2");
    step(0, 5'd0, 5'd5, 5'd0, 1, 0, 0, 0, N, "cnt_i2", 1'b1, 2'd2);
    step(1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, B, "cnt_b3");
    step(0, 5'd0, 5'd5, 5'd0, 1, 0, 0, 0, N, "cnt_i3", 1'b1, 2'd3);
    step(1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, B, "cnt_b4");
    step(0, 5'd0, 5'd5, 5'd0, 1, 0, 0, 0, N, "cnt_i4", 1'b1, 2'd3);
    step(1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, B, "cnt_b5");
    step(0, 5'd0, 5'd5, 5'd0, 1, 0, 0, 0, N, "cnt_sat", 1'b1, 2'd3);

    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      @(negedge clk); #1;
    end
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d records left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
